// File: rtl/sel_arb_pkg.sv
// Shared types and selector encodings for the two-source packet arbiter.
package sel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sel_datapath.sv
// W-bit 2:1 selector; sel=SEL_B routes inb, otherwise ina. Purely combinational.
module sel_datapath
  import sel_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] ina,
  input  logic [W-1:0] inb,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = (sel == SEL_B) ? inb : ina;

endmodule

// File: rtl/sel_arbiter.sv
// Packet-level round-robin arbiter for two valid/ready/last sources over one shared selector.
// Build option SEL_ARB_BURST_LIMIT_EN: yield after MAX_BEATS beats when the other source waits.
module sel_arbiter
  import sel_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy
);

  state_t       state, state_nx;
  logic         sel_nx;
  logic         last_served, ls_nx;
  logic [W+1:0] mux;
  logic         xfer;
  logic         oth_valid;
  logic         limit_hit;

  // valid and last ride through the same selector as the data
  sel_datapath #(.W(W + 2)) u_dp (
    .ina ({a_valid, a_last, a_data}),
    .inb ({b_valid, b_last, b_data}),
    .sel (sel),
    .out (mux)
  );

  assign busy      = (state != IDLE);
  assign out_valid = busy & mux[W+1];
  assign out_last  = busy & mux[W];
  assign out_data  = mux[W-1:0];
  assign a_ready   = (state == GRANT_A) & out_ready;
  assign b_ready   = (state == GRANT_B) & out_ready;
  assign xfer      = out_valid & out_ready;
  assign oth_valid = (sel == SEL_A) ? b_valid : a_valid;

`ifdef SEL_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BEATS + 1);
  logic [CW-1:0] beat_cnt;
  logic          regrant;

  assign regrant   = (state_nx != IDLE) && (state_nx != state);
  assign limit_hit = (beat_cnt >= CW'(MAX_BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beat_cnt <= '0;
    else if (regrant)
      beat_cnt <= '0;
    else if (xfer && (beat_cnt != CW'(MAX_BEATS)))
      beat_cnt <= beat_cnt + CW'(1);
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ls_nx    = last_served;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || (last_served == SEL_B))) begin
          state_nx = GRANT_A;
          sel_nx   = SEL_A;
        end else if (b_valid) begin
          state_nx = GRANT_B;
          sel_nx   = SEL_B;
        end
      end
      GRANT_A, GRANT_B: begin
        // The granted valid at this edge belongs to the beat being consumed, so it
        // cannot announce a follow-on packet; without a waiting peer we drop to IDLE.
        if (xfer && (mux[W] || limit_hit)) begin
          if (mux[W])
            ls_nx = sel;
          if (oth_valid) begin
            state_nx = (sel == SEL_A) ? GRANT_B : GRANT_A;
            sel_nx   = ~sel;
          end else if (mux[W]) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= SEL_A;
      last_served <= SEL_B;
    end else begin
      state       <= state_nx;
      sel         <= sel_nx;
      last_served <= ls_nx;
    end
  end

endmodule
